single_clk_fwft_fifo: RTL and testbench

- Parametrised single-clock FIFO built on an inferred dual-address block RAM with registered read data (1-cycle read latency).
- Presents a first-word-fall-through interface: the head word is always visible on data_out when data_valid=1, and a read pops it.
- Adds occupancy count, almost-full/almost-empty flags, overflow/underflow pulses and synchronous clear.
- Serves as the standard buffering element between streaming blocks (UART, DSP, bus bridges).

---
 rtl/single_clk_fwft_fifo.sv | 165 ++++++++++++++++
 tb/tb_single_clk_fwft_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/single_clk_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO. A block RAM with a registered read
// feeds a two-entry prefetch stage (output register plus skid) so the head word is always presented.
module single_clk_fwft_fifo #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 8,
    parameter int ALMOST_FULL_LEVEL  = 2**ADDR_WIDTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AF_LVL  = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AE_LVL  = ALMOST_EMPTY_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
    logic [DATA_WIDTH-1:0] ram_q_r, skid_d_r, out_d_r;
    logic                  ram_q_v_r, skid_v_r, out_v_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  full_r, af_r, ae_r, ovf_r, unf_r;

    logic                  wr_acc_s, rd_acc_s, issue_s;
    logic [1:0]            pipe_cnt_s, pipe_after_pop_s;
    logic [ADDR_WIDTH:0]   ram_words_s, count_next_s;
    logic                  out_v_n_s, skid_v_n_s;
    logic [DATA_WIDTH-1:0] out_d_n_s, skid_d_n_s;
    logic                  full_n_s, af_n_s, ae_n_s;

    // Acceptance, RAM read issue and occupancy arithmetic
    always_comb begin
        wr_acc_s         = write_enable && !full_r && !sync_reset;
        rd_acc_s         = read_enable && out_v_r && !sync_reset;
        pipe_cnt_s       = {1'b0, out_v_r} + {1'b0, skid_v_r} + {1'b0, ram_q_v_r};
        pipe_after_pop_s = pipe_cnt_s - {1'b0, rd_acc_s};
        // Words still parked in RAM = accepted words minus those already in the prefetch path.
        ram_words_s      = count_r - {{(ADDR_WIDTH-1){1'b0}}, pipe_cnt_s};
        // A word read now lands next cycle, so out+skid must have a free slot even without a pop.
        issue_s          = !sync_reset && (ram_words_s != {(ADDR_WIDTH+1){1'b0}})
                           && (pipe_after_pop_s <= 2'd1);
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
        full_n_s = (count_next_s == DEPTH_C);
        af_n_s   = (count_next_s >= AF_LVL);
        ae_n_s   = (count_next_s <= AE_LVL);
    end

    // Prefetch stage steering: output register refills from skid first, then from RAM data
    always_comb begin
        out_v_n_s  = out_v_r;
        out_d_n_s  = out_d_r;
        skid_v_n_s = skid_v_r;
        skid_d_n_s = skid_d_r;
        if (!out_v_r || rd_acc_s) begin
            if (skid_v_r) begin
                out_v_n_s  = 1'b1;
                out_d_n_s  = skid_d_r;
                skid_v_n_s = ram_q_v_r;
                skid_d_n_s = ram_q_r;
            end else if (ram_q_v_r) begin
                out_v_n_s  = 1'b1;
                out_d_n_s  = ram_q_r;
            end else begin
                out_v_n_s  = 1'b0;
            end
        end else begin
            if (ram_q_v_r) begin
                skid_v_n_s = 1'b1;
                skid_d_n_s = ram_q_r;
            end else begin
                skid_v_n_s = skid_v_r;
            end
        end
    end

    // Storage array with registered read port; contents are never cleared
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
        if (issue_s) begin
            ram_q_r <= mem_r[rd_ptr_r];
        end
    end

    // Pointers, prefetch state, occupancy and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r  <= {ADDR_WIDTH{1'b0}};
            ram_q_v_r <= 1'b0;
            skid_v_r  <= 1'b0;
            skid_d_r  <= {DATA_WIDTH{1'b0}};
            out_v_r   <= 1'b0;
            out_d_r   <= {DATA_WIDTH{1'b0}};
            count_r   <= {(ADDR_WIDTH+1){1'b0}};
            full_r    <= 1'b0;
            af_r      <= 1'b0;
            ae_r      <= 1'b1;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else if (sync_reset) begin
            wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r  <= {ADDR_WIDTH{1'b0}};
            ram_q_v_r <= 1'b0;
            skid_v_r  <= 1'b0;
            skid_d_r  <= {DATA_WIDTH{1'b0}};
            out_v_r   <= 1'b0;
            out_d_r   <= {DATA_WIDTH{1'b0}};
            count_r   <= {(ADDR_WIDTH+1){1'b0}};
            full_r    <= 1'b0;
            af_r      <= 1'b0;
            ae_r      <= 1'b1;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            ram_q_v_r <= issue_s;
            skid_v_r  <= skid_v_n_s;
            skid_d_r  <= skid_d_n_s;
            out_v_r   <= out_v_n_s;
            out_d_r   <= out_d_n_s;
            count_r   <= count_next_s;
            full_r    <= full_n_s;
            af_r      <= af_n_s;
            ae_r      <= ae_n_s;
            ovf_r     <= write_enable && full_r;
            unf_r     <= read_enable && !out_v_r;
        end
    end

    assign data_out     = out_d_r;
    assign data_valid   = out_v_r;
    assign count        = count_r;
    assign full         = full_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_single_clk_fwft_fifo.sv
// Self-checking bench for single_clk_fwft_fifo (8-deep instance): vector table,
// directed corner sequences and random traffic against a queue-based reference model.
module tb_single_clk_fwft_fifo;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset_n, sync_reset, write_enable, read_enable;
    logic [DW-1:0] data_in, data_out;
    logic          data_valid, full, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    single_clk_fwft_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_LEVEL(AF), .ALMOST_EMPTY_LEVEL(AE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .write_enable(write_enable), .data_in(data_in), .read_enable(read_enable),
        .data_out(data_out), .data_valid(data_valid), .count(count), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    // Reference model: each stored word remembers the edge that wrote it; the head
    // is visible once two edges have passed since its write.
    typedef struct { logic [DW-1:0] d; int w; } entry_t;
    entry_t q[$];
    int     edge_n = 0;
    logic   m_ovf = 1'b0, m_unf = 1'b0;
    int     tests = 0, fails = 0;

    typedef struct {
        logic we; logic [DW-1:0] din; logic re;
        int cnt; logic v; logic [DW-1:0] dout; logic ae; logic unf;
    } vec_t;
    vec_t vecs [15];

    function automatic logic m_valid(int t);
        if (q.size() == 0) return 1'b0;
        return (t - q[0].w) >= 2;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        logic   vpre;
        int     sz;
        entry_t e;
        vpre = m_valid(edge_n);
        sz   = q.size();
        edge_n++;
        if (sync_reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = write_enable && (sz == DEPTH);
            m_unf = read_enable && !vpre;
            if (read_enable && vpre) q.delete(0);
            if (write_enable && sz < DEPTH) begin
                e.d = data_in;
                e.w = edge_n;
                q.push_back(e);
            end
        end
    endtask

    task automatic compare_model();
        logic v;
        v = m_valid(edge_n);
        check("m_count", int'(count), q.size());
        check("m_full", int'(full), int'(q.size() == DEPTH));
        check("m_almost_full", int'(almost_full), int'(q.size() >= AF));
        check("m_almost_empty", int'(almost_empty), int'(q.size() <= AE));
        check("m_overflow", int'(overflow), int'(m_ovf));
        check("m_underflow", int'(underflow), int'(m_unf));
        check("m_data_valid", int'(data_valid), int'(v));
        if (v) check("m_data_out", int'(data_out), int'(q[0].d));
    endtask

    task automatic step(input logic we, input logic [DW-1:0] din, input logic re, input logic sr);
        write_enable = we;
        data_in      = din;
        read_enable  = re;
        sync_reset   = sr;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    initial begin
        reset_n = 1'b0; sync_reset = 1'b0; write_enable = 1'b0; read_enable = 1'b0; data_in = '0;

        // {we, din, re, count, valid, data_out, almost_empty, underflow} after the edge
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h5A, 1'b1, 1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h6B, 1'b0, 2, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h7C, 1'b0, 3, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h6B, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h7C, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_count", int'(count), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_full", int'(full), 0);
        check("rst_almost_full", int'(almost_full), 0);
        check("rst_almost_empty", int'(almost_empty), 1);
        check("rst_overflow", int'(overflow), 0);
        check("rst_underflow", int'(underflow), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].we, vecs[i].din, vecs[i].re, 1'b0);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
            check($sformatf("vec%0d_valid", i), int'(data_valid), int'(vecs[i].v));
            if (vecs[i].v) check($sformatf("vec%0d_data", i), int'(data_out), int'(vecs[i].dout));
            check($sformatf("vec%0d_aempty", i), int'(almost_empty), int'(vecs[i].ae));
            check($sformatf("vec%0d_underflow", i), int'(underflow), int'(vecs[i].unf));
        end

        // Fill to full, overflow, then drain back-to-back
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 8);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_count", int'(count), 8);
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", int'(data_valid), 1);
            check("drain_data", int'(data_out), i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_empty_valid", int'(data_valid), 0);
        check("drain_empty_count", int'(count), 0);

        // Sustained simultaneous push/pop across pointer wraps
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("stream_valid", int'(data_valid), 1);
            check("stream_data", int'(data_out), i);
            step(1'b1, 8'(i + 4), 1'b1, 1'b0);
            check("stream_count", int'(count), 4);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Synchronous clear wins over a simultaneous write and read
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_srst_count", int'(count), 5);
        step(1'b1, 8'h99, 1'b1, 1'b1);
        check("srst_count", int'(count), 0);
        check("srst_valid", int'(data_valid), 0);
        check("srst_ovf", int'(overflow), 0);
        check("srst_unf", int'(underflow), 0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("srst_wr_not_yet", int'(data_valid), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("srst_wr_valid", int'(data_valid), 1);
        check("srst_wr_data", int'(data_out), 8'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check("pre_arst_count", int'(count), 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_valid", int'(data_valid), 0);
        check("arst_aempty", int'(almost_empty), 1);
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        @(posedge clk); edge_n++;
        @(posedge clk); edge_n++;
        #1;
        reset_n = 1'b1;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("arst_wr_valid", int'(data_valid), 1);
        check("arst_wr_data", int'(data_out), 8'h11);

        // Random traffic with shifting push/pop bias and rare clears
        for (int blk = 0; blk < 5; blk++) begin
            int pw, pr;
            pw = 20 + blk * 15;
            pr = 80 - blk * 15;
            for (int c = 0; c < 120; c++) begin
                step($urandom_range(0, 99) < pw, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < pr, $urandom_range(0, 149) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
